// File: rtl/led_frame_scheduler.sv
// led_frame_scheduler
//   Reads the LED frame buffer BRAM once per frame and deals the bytes out
//   round-robin to per-channel one-byte holding slots. Channel c's bytes live
//   in the contiguous region starting at c*CHANNEL_BYTES. Each slot feeds a
//   strip driver over a valid/ready handshake; a stalled strip never blocks
//   the others.
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous active-low reset
//   frame_start  one-cycle pulse, starts a frame (accepted only when idle)
//   frame_abort  one-cycle pulse, abandons the current frame
//   frame_busy   high from frame acceptance until done or abort
//   frame_done   one-cycle pulse once every byte of every channel is accepted
//   mem_addr     registered BRAM read address
//   mem_dout     BRAM read data, valid one cycle after mem_addr
//   ch_data      slot data, channel c in bits [8c+7:8c]
//   ch_valid     slot full
//   ch_last      slot holds the final byte of that channel's frame
//   ch_ready     strip driver accepts the slot
module led_frame_scheduler #(
    parameter int ADDRESS_WIDTH = 13,
    parameter int NUM_CHANNELS  = 4,
    parameter int CHANNEL_BYTES = 1536
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      frame_start,
    input  logic                      frame_abort,
    output logic                      frame_busy,
    output logic                      frame_done,
    output logic [ADDRESS_WIDTH-1:0]  mem_addr,
    input  logic [7:0]                mem_dout,
    output logic [NUM_CHANNELS*8-1:0] ch_data,
    output logic [NUM_CHANNELS-1:0]   ch_valid,
    output logic [NUM_CHANNELS-1:0]   ch_last,
    input  logic [NUM_CHANNELS-1:0]   ch_ready
);

    localparam int CW = $clog2(CHANNEL_BYTES + 1);
    localparam int GW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam logic [CW-1:0] CNT_FULL = CW'(CHANNEL_BYTES);
    localparam logic [CW-1:0] CNT_LAST = CW'(CHANNEL_BYTES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARB,
        S_WAIT,
        S_CAPTURE,
        S_DONE
    } state_t;

    state_t        state;
    logic [CW-1:0] count [NUM_CHANNELS];
    // Last granted channel; also the channel being fetched in WAIT/CAPTURE.
    logic [GW-1:0] ptr;

    logic                     arb_found;
    logic [GW-1:0]            arb_sel;
    logic [ADDRESS_WIDTH-1:0] arb_addr;
    logic                     all_done;

    function automatic int unsigned rr_index(input logic [GW-1:0] p, input int unsigned off);
        return (32'(p) + off) % NUM_CHANNELS;
    endfunction

    // Round-robin search starting one past the last grant.
    always_comb begin
        arb_found = 1'b0;
        arb_sel   = ptr;
        arb_addr  = '0;
        all_done  = 1'b1;
        for (int unsigned i = 1; i <= NUM_CHANNELS; i++) begin
            if (!arb_found && !ch_valid[rr_index(ptr, i)] &&
                (count[rr_index(ptr, i)] < CNT_FULL)) begin
                arb_found = 1'b1;
                arb_sel   = GW'(rr_index(ptr, i));
                arb_addr  = ADDRESS_WIDTH'(rr_index(ptr, i) * CHANNEL_BYTES) +
                            ADDRESS_WIDTH'(count[rr_index(ptr, i)]);
            end
        end
        for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
            if (ch_valid[c] || (count[c] != CNT_FULL)) begin
                all_done = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            mem_addr   <= '0;
            ch_data    <= '0;
            ch_valid   <= '0;
            ch_last    <= '0;
            frame_busy <= 1'b0;
            frame_done <= 1'b0;
            ptr        <= GW'(NUM_CHANNELS - 1);
            for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
                count[c] <= '0;
            end
        end else begin
            frame_done <= 1'b0;

            // Handshake clears come first; CAPTURE only ever targets an empty
            // slot, so its set never lands on a bit cleared here.
            for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
                if (ch_valid[c] && ch_ready[c]) begin
                    ch_valid[c] <= 1'b0;
                    ch_last[c]  <= 1'b0;
                end
            end

            if (frame_abort && (state != S_IDLE)) begin
                // Dropping out of WAIT/CAPTURE discards the in-flight read.
                state      <= S_IDLE;
                ch_valid   <= '0;
                ch_last    <= '0;
                frame_busy <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (frame_start) begin
                            for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
                                count[c] <= '0;
                            end
                            frame_busy <= 1'b1;
                            state      <= S_ARB;
                        end
                    end
                    S_ARB: begin
                        if (arb_found) begin
                            mem_addr <= arb_addr;
                            ptr      <= arb_sel;
                            state    <= S_WAIT;
                        end else if (all_done) begin
                            frame_done <= 1'b1;
                            state      <= S_DONE;
                        end
                    end
                    S_WAIT: begin
                        state <= S_CAPTURE;
                    end
                    S_CAPTURE: begin
                        for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
                            if (GW'(c) == ptr) begin
                                ch_data[8*c +: 8] <= mem_dout;
                                ch_valid[c]       <= 1'b1;
                                ch_last[c]        <= (count[c] == CNT_LAST);
                                count[c]          <= count[c] + CW'(1);
                            end
                        end
                        state <= S_ARB;
                    end
                    S_DONE: begin
                        frame_busy <= 1'b0;
                        state      <= S_IDLE;
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
